// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS EX-stage forwarding logic: forwarding
// select encodings, the hard-wired zero register and default widths.
// Latency: n/a (types and constants only). Backpressure: n/a.
package mips_pkg;

  // Default data width; also the number of architectural registers.
  localparam int LENGHT_IN_DEF = 32;
  // Default register-address width, $clog2(LENGHT_IN_DEF).
  localparam int NB_DEF        = 5;
  // Default width of the debug statistics counters.
  localparam int CNT_W_DEF     = 32;

  typedef logic [1:0] fwd_sel_t;

  // Operand source selects. 2'b11 is never produced.
  localparam fwd_sel_t FWD_NONE   = 2'b00;  // register-file value read in ID
  localparam fwd_sel_t FWD_EX_MEM = 2'b10;  // EX/MEM ALU result
  localparam fwd_sel_t FWD_MEM_WB = 2'b01;  // MEM/WB write-back value

  // $zero: writes to it are discarded, so it is never a forwarding target.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/forwarding_select.sv
// Forwarding decision and data mux for one ALU source operand.
// Latency: purely combinational, zero cycles. Backpressure: none.
// Ports:
//   register_write_3_4/4_5  write enables of the EX/MEM and MEM/WB instructions
//   rd_3_4/rd_4_5           destination registers of those instructions
//   src_reg                 ID/EX source register field (rs or rt)
//   data_reg                value of src_reg read from the register file in ID
//   data_3_4/data_4_5       EX/MEM ALU result, MEM/WB write-back value
//   fwd_sel                 chosen source (FWD_NONE / FWD_EX_MEM / FWD_MEM_WB)
//   operand                 forwarded operand value
module forwarding_select
  import mips_pkg::*;
#(
  parameter int lenghtIN = LENGHT_IN_DEF,
  parameter int NB       = NB_DEF
) (
  input  logic                register_write_3_4,
  input  logic                register_write_4_5,
  input  logic [NB-1:0]       rd_3_4,
  input  logic [NB-1:0]       rd_4_5,
  input  logic [NB-1:0]       src_reg,
  input  logic [lenghtIN-1:0] data_reg,
  input  logic [lenghtIN-1:0] data_3_4,
  input  logic [lenghtIN-1:0] data_4_5,
  output fwd_sel_t            fwd_sel,
  output logic [lenghtIN-1:0] operand
);

  logic hit_3_4;
  logic hit_4_5;

  // A stage is a forwarding candidate only if it really writes a register
  // other than $zero and that register is the one this operand reads.
  assign hit_3_4 = register_write_3_4 && (rd_3_4 != NB'(ZERO_REG)) && (rd_3_4 == src_reg);
  assign hit_4_5 = register_write_4_5 && (rd_4_5 != NB'(ZERO_REG)) && (rd_4_5 == src_reg);

  // EX/MEM is checked first: it holds the younger, more recent value.
  always_comb begin
    fwd_sel = FWD_NONE;
    if (hit_3_4) begin
      fwd_sel = FWD_EX_MEM;
    end else if (hit_4_5) begin
      fwd_sel = FWD_MEM_WB;
    end
  end

  always_comb begin
    operand = data_reg;
    case (fwd_sel)
      FWD_EX_MEM: operand = data_3_4;
      FWD_MEM_WB: operand = data_4_5;
      default:    operand = data_reg;
    endcase
  end

endmodule

// File: rtl/mips_forwarding_unit.sv
// EX-stage data-hazard forwarding for rs/rt plus saturating debug counters
// of EX/MEM and MEM/WB forwarding cycles.
// Latency: selects/operands combinational (0 cycles); counters update on the
// CLK100MHZ rising edge. Backpressure: none; count_enable=0 (stall) freezes
// the counters only.
// Ports:
//   CLK100MHZ, reset        counter clock, synchronous active-high counter clear
//   register_write_*, rd_*  EX/MEM and MEM/WB destination info
//   rs_2_3, rt_2_3          ID/EX source register fields
//   data_*                  register-file values and pipeline result values
//   count_enable            pipeline advances this cycle
//   forward_a/b, operand_a/b  forwarding selects and forwarded values
//   fwd_count_3_4/4_5       cycles with any EX/MEM / MEM/WB forward
module mips_forwarding_unit
  import mips_pkg::*;
#(
  parameter int lenghtIN = LENGHT_IN_DEF,
  parameter int NB       = NB_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic                register_write_3_4,
  input  logic                register_write_4_5,
  input  logic [NB-1:0]       rd_3_4,
  input  logic [NB-1:0]       rd_4_5,
  input  logic [NB-1:0]       rs_2_3,
  input  logic [NB-1:0]       rt_2_3,
  input  logic [lenghtIN-1:0] data_rs_2_3,
  input  logic [lenghtIN-1:0] data_rt_2_3,
  input  logic [lenghtIN-1:0] data_3_4,
  input  logic [lenghtIN-1:0] data_4_5,
  input  logic                count_enable,
  output logic [1:0]          forward_a,
  output logic [1:0]          forward_b,
  output logic [lenghtIN-1:0] operand_a,
  output logic [lenghtIN-1:0] operand_b,
  output logic [CNT_W-1:0]    fwd_count_3_4,
  output logic [CNT_W-1:0]    fwd_count_4_5
);

  forwarding_select #(.lenghtIN(lenghtIN), .NB(NB)) u_sel_rs (
    .register_write_3_4 (register_write_3_4),
    .register_write_4_5 (register_write_4_5),
    .rd_3_4             (rd_3_4),
    .rd_4_5             (rd_4_5),
    .src_reg            (rs_2_3),
    .data_reg           (data_rs_2_3),
    .data_3_4           (data_3_4),
    .data_4_5           (data_4_5),
    .fwd_sel            (forward_a),
    .operand            (operand_a)
  );

  forwarding_select #(.lenghtIN(lenghtIN), .NB(NB)) u_sel_rt (
    .register_write_3_4 (register_write_3_4),
    .register_write_4_5 (register_write_4_5),
    .rd_3_4             (rd_3_4),
    .rd_4_5             (rd_4_5),
    .src_reg            (rt_2_3),
    .data_reg           (data_rt_2_3),
    .data_3_4           (data_3_4),
    .data_4_5           (data_4_5),
    .fwd_sel            (forward_b),
    .operand            (operand_b)
  );

  // One event per cycle even when both operands forward from the same stage.
  logic any_fwd_3_4;
  logic any_fwd_4_5;

  assign any_fwd_3_4 = (forward_a == FWD_EX_MEM) || (forward_b == FWD_EX_MEM);
  assign any_fwd_4_5 = (forward_a == FWD_MEM_WB) || (forward_b == FWD_MEM_WB);

  // Saturating counters: holding at all-ones keeps a long run from wrapping
  // back to a misleadingly small number. Reset wins over increment.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      fwd_count_3_4 <= '0;
      fwd_count_4_5 <= '0;
    end else begin
      if (count_enable && any_fwd_3_4 && (fwd_count_3_4 != '1)) begin
        fwd_count_3_4 <= fwd_count_3_4 + CNT_W'(1);
      end
      if (count_enable && any_fwd_4_5 && (fwd_count_4_5 != '1)) begin
        fwd_count_4_5 <= fwd_count_4_5 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_forwarding_unit.sv
module tb_mips_forwarding_unit;

  logic        clk;
  logic        reset;
  logic        register_write_3_4, register_write_4_5;
  logic [4:0]  rd_3_4, rd_4_5, rs_2_3, rt_2_3;
  logic [31:0] data_rs_2_3, data_rt_2_3, data_3_4, data_4_5;
  logic        count_enable;

  logic [1:0]  forward_a, forward_b;
  logic [31:0] operand_a, operand_b;
  logic [31:0] fwd_count_3_4, fwd_count_4_5;

  logic [1:0]  s_forward_a, s_forward_b;
  logic [31:0] s_operand_a, s_operand_b;
  logic [1:0]  s_count_3_4, s_count_4_5;

  mips_forwarding_unit dut (
    .CLK100MHZ(clk), .reset(reset),
    .register_write_3_4(register_write_3_4), .register_write_4_5(register_write_4_5),
    .rd_3_4(rd_3_4), .rd_4_5(rd_4_5), .rs_2_3(rs_2_3), .rt_2_3(rt_2_3),
    .data_rs_2_3(data_rs_2_3), .data_rt_2_3(data_rt_2_3),
    .data_3_4(data_3_4), .data_4_5(data_4_5), .count_enable(count_enable),
    .forward_a(forward_a), .forward_b(forward_b),
    .operand_a(operand_a), .operand_b(operand_b),
    .fwd_count_3_4(fwd_count_3_4), .fwd_count_4_5(fwd_count_4_5)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  mips_forwarding_unit #(.CNT_W(2)) dut_sat (
    .CLK100MHZ(clk), .reset(reset),
    .register_write_3_4(register_write_3_4), .register_write_4_5(register_write_4_5),
    .rd_3_4(rd_3_4), .rd_4_5(rd_4_5), .rs_2_3(rs_2_3), .rt_2_3(rt_2_3),
    .data_rs_2_3(data_rs_2_3), .data_rt_2_3(data_rt_2_3),
    .data_3_4(data_3_4), .data_4_5(data_4_5), .count_enable(count_enable),
    .forward_a(s_forward_a), .forward_b(s_forward_b),
    .operand_a(s_operand_a), .operand_b(s_operand_b),
    .fwd_count_3_4(s_count_3_4), .fwd_count_4_5(s_count_4_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fa, fb;
    logic [31:0] oa, ob;
    logic        cnt_known;
    logic [31:0] c34, c45;
    logic [1:0]  s34, s45;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  // Reference model state.
  logic        m_cnt_known = 0;
  longint      m_c34 = 0, m_c45 = 0;   // unbounded counts, clipped on compare
  bit          p_rst = 1, p_ce = 0, p_used34 = 0, p_used45 = 0;

  // Which stage supplies a source register: walk the in-flight writers from
  // youngest to oldest and take the first real (non-$zero) write to it.
  function automatic void resolve(input logic [4:0] src, input logic [31:0] rf_val,
                                  output logic [1:0] sel, output logic [31:0] val);
    logic        wr [2];
    logic [4:0]  rd [2];
    logic [31:0] dv [2];
    logic [1:0]  code [2];
    wr[0] = register_write_3_4; rd[0] = rd_3_4; dv[0] = data_3_4; code[0] = 2'b10;
    wr[1] = register_write_4_5; rd[1] = rd_4_5; dv[1] = data_4_5; code[1] = 2'b01;
    sel = 2'b00;
    val = rf_val;
    if (src == 5'd0) return;
    for (int i = 0; i < 2; i++) begin
      if (wr[i] && rd[i] == src) begin
        sel = code[i];
        val = dv[i];
        return;
      end
    end
  endfunction

  function automatic longint clip(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic apply(input logic rst, input logic ce, input logic w34, input logic w45,
                       input logic [4:0] r34, input logic [4:0] r45,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] ds, input logic [31:0] dt,
                       input logic [31:0] d34, input logic [31:0] d45);
    exp_t e;
    @(posedge clk);
    #1;
    // Account for the edge just taken, using the inputs held across it.
    if (p_rst) begin
      m_c34 = 0; m_c45 = 0; m_cnt_known = 1;
    end else if (p_ce) begin
      if (p_used34) m_c34++;
      if (p_used45) m_c45++;
    end
    reset = rst; count_enable = ce;
    register_write_3_4 = w34; register_write_4_5 = w45;
    rd_3_4 = r34; rd_4_5 = r45; rs_2_3 = rs; rt_2_3 = rt;
    data_rs_2_3 = ds; data_rt_2_3 = dt; data_3_4 = d34; data_4_5 = d45;
    resolve(rs, ds, e.fa, e.oa);
    resolve(rt, dt, e.fb, e.ob);
    e.cnt_known = m_cnt_known;
    e.c34 = 32'(clip(m_c34, 64'hFFFF_FFFF));
    e.c45 = 32'(clip(m_c45, 64'hFFFF_FFFF));
    e.s34 = 2'(clip(m_c34, 3));
    e.s45 = 2'(clip(m_c45, 3));
    exp_q.push_back(e);
    p_rst = rst; p_ce = ce;
    p_used34 = (e.fa == 2'b10) || (e.fb == 2'b10);
    p_used45 = (e.fa == 2'b01) || (e.fb == 2'b01);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: combinational outputs are presented every cycle; sample on the
  // falling edge, away from the counter update.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("forward_a", 32'(forward_a), 32'(e.fa));
      chk("forward_b", 32'(forward_b), 32'(e.fb));
      chk("operand_a", operand_a, e.oa);
      chk("operand_b", operand_b, e.ob);
      chk("sat_forward_a", 32'(s_forward_a), 32'(e.fa));
      chk("sat_operand_b", s_operand_b, e.ob);
      if (e.cnt_known) begin
        chk("fwd_count_3_4", fwd_count_3_4, e.c34);
        chk("fwd_count_4_5", fwd_count_4_5, e.c45);
        chk("sat_count_3_4", 32'(s_count_3_4), 32'(e.s34));
        chk("sat_count_4_5", 32'(s_count_4_5), 32'(e.s45));
      end
    end
  end

  initial begin
    reset = 1; count_enable = 0;
    register_write_3_4 = 0; register_write_4_5 = 0;
    rd_3_4 = 0; rd_4_5 = 0; rs_2_3 = 0; rt_2_3 = 0;
    data_rs_2_3 = 0; data_rt_2_3 = 0; data_3_4 = 0; data_4_5 = 0;

    apply(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    // $zero reads never forward, whatever the writers do.
    for (int i = 0; i < 16; i++) begin
      apply(0, 1, i[0], i[1], {4'd0, i[2]}, {4'd0, i[3]}, 5'd0, 5'd0,
            32'h1111_0000 + i, 32'h2222_0000 + i, 32'hAAAA_0000 + i, 32'hBBBB_0000 + i);
    end

    // Both stages write rs: EX/MEM wins.
    apply(0, 1, 1, 1, 5'd1, 5'd1, 5'd1, 5'd2, 32'h0000_1111, 32'h0000_2222, 32'hC0FF_EE00, 32'h0BAD_F00D);
    // Only MEM/WB writes rt.
    apply(0, 1, 0, 1, 5'd1, 5'd1, 5'd7, 5'd1, 32'h0000_3333, 32'h0000_4444, 32'h1234_5678, 32'hDEAD_BEEF);
    // No match at all.
    apply(0, 1, 1, 1, 5'd4, 5'd5, 5'd3, 5'd6, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888);

    // Counters: clear, 3 cycles of EX/MEM forward on both operands, 2 stalled
    // cycles, then a single reset cycle.
    apply(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      apply(0, 1, 1, 0, 5'd2, 5'd0, 5'd2, 5'd2, 32'h1, 32'h2, 32'h3 + i, 32'h4);
    for (int i = 0; i < 2; i++)
      apply(0, 0, 1, 0, 5'd2, 5'd0, 5'd2, 5'd2, 32'h1, 32'h2, 32'h3, 32'h4);
    apply(1, 1, 1, 1, 5'd2, 5'd3, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 32'h4);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Saturation on the narrow copy: 5 MEM/WB forward cycles, max is 3.
    for (int i = 0; i < 5; i++)
      apply(0, 1, 0, 1, 5'd0, 5'd1, 5'd9, 5'd1, 32'h9, 32'hA, 32'hB, 32'hDEAD_BEEF);

    // Random traffic over a small register range so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, $urandom);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    stim_done = 1;

    // Monitor must drain the scoreboard within a few cycles.
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_forwarding_unit.md
# mips_forwarding_unit

Combinational data-hazard forwarding block for the EX stage of the 5-stage MIPS pipeline. For each ALU source operand, it compares the ID/EX source registers (rs, rt) with the destination registers of the EX/MEM and MEM/WB stages. It produces forwarding selects and the forwarded operand values. A small clocked statistics section counts forwarding events for debug.

## Interface
- lenghtIN, default 32: data width and number of architectural registers.
- NB, default 5 ($clog2(lenghtIN)): register-address width.

- CLK100MHZ  in  1  system clock; used only by the statistics counters.
- reset  in  1  synchronous, active-high; clears the counters.
- register_write_3_4  in  1  EX/MEM instruction writes the register file.
- register_write_4_5  in  1  MEM/WB instruction writes the register file.
- rd_3_4  in  NB  EX/MEM destination register.
- rd_4_5  in  NB  MEM/WB destination register.
- rs_2_3  in  NB  ID/EX rs field.
- rt_2_3  in  NB  ID/EX rt field.
- data_rs_2_3  in  lenghtIN  rs value read in ID.
- data_rt_2_3  in  lenghtIN  rt value read in ID.
- data_3_4  in  lenghtIN  EX/MEM ALU result.
- data_4_5  in  lenghtIN  MEM/WB write-back value.
- count_enable  in  1  pipeline advances this cycle (not stalled).
- forward_a  out  2  select for operand A (rs).
- forward_b  out  2  select for operand B (rt).
- operand_a  out  lenghtIN  forwarded rs value.
- operand_b  out  lenghtIN  forwarded rt value.
- fwd_count_3_4  out  32  cycles with any EX/MEM forward.
- fwd_count_4_5  out  32  cycles with any MEM/WB forward.

## Operation
- Select encoding: 2'b00 = register file (no forward), 2'b10 = EX/MEM, 2'b01 = MEM/WB, 2'b11 = never produced.
- forward_a = 2'b10 if register_write_3_4 && rd_3_4 != 0 && rd_3_4 == rs_2_3.
- Otherwise, forward_a = 2'b01 if register_write_4_5 && rd_4_5 != 0 && rd_4_5 == rs_2_3.
- Otherwise, forward_a = 2'b00.
- forward_b is identical, using rt_2_3.
- Register 0 ($zero) is never forwarded, even when the write enable is high and the addresses match.
- When both stages match, EX/MEM wins because it holds the most recent value.
- operand_x mux: 00 → data_r*_2_3, 10 → data_3_4, 01 → data_4_5.
- Counters:
  - fwd_count_3_4 increments by 1 when count_enable is high and forward_a == 10 or forward_b == 10.
  - fwd_count_4_5 increments by 1 when count_enable is high and forward_a == 01 or forward_b == 01.
  - Each counter increments at most once per cycle and saturates at 32'hFFFF_FFFF.

## Timing
- forward_a/b and operand_a/b are purely combinational, with zero-cycle latency.
- No register sits in the forwarding path.
- Reset has no effect on the combinational outputs.
- Counters update on the CLK100MHZ rising edge.
- When reset is high at an edge, both counters read 0 after that edge. Reset overrides increment.
- Counter reset value is 0. Before the first reset, counter contents are undefined.
- Inputs must be stable within one clock period. There is no handshake.

## Structure
- Shared package mips_pkg holds:
  - FWD_NONE = 2'b00, FWD_EX_MEM = 2'b10, FWD_MEM_WB = 2'b01.
  - ZERO_REG = 0.
  - The default widths.
- Sub-module forwarding_select: one operand's compare, priority and data mux. It is instantiated twice (rs, rt).
- The top level adds the counters.

## Test plan
- All combinations of register_write_3_4 / register_write_4_5 ∈ {0,1} and rd_3_4 / rd_4_5 ∈ {0,1}, with rs_2_3 = rt_2_3 = 0 → forward_a = forward_b = 00 in every case; counters stay 0.
- rs_2_3 = 1, rd_3_4 = 1, register_write_3_4 = 1, rd_4_5 = 1, register_write_4_5 = 1 → forward_a = 10 and operand_a = data_3_4 (EX/MEM priority).
- rt_2_3 = 1, register_write_3_4 = 0, rd_4_5 = 1, register_write_4_5 = 1, data_4_5 = 32'hDEADBEEF → forward_b = 01, operand_b = 32'hDEADBEEF.
- rs_2_3 = 3, rd_3_4 = 4, rd_4_5 = 5, both write enables = 1 → forward_a = 00 and operand_a = data_rs_2_3.
- Counters, with count_enable = 1:
  - Hold an EX/MEM forward on both operands for 3 cycles → fwd_count_3_4 = 3 (not 6).
  - Drop count_enable for 2 cycles → no change.
  - Assert reset for 1 cycle → both counters 0 on the next edge.
- Force fwd_count_4_5 to 32'hFFFF_FFFE and apply 3 MEM/WB forward cycles → counter saturates at 32'hFFFF_FFFF.
